// File: rtl/control_unit_pipe.sv
// Registered ID/EX control decoder: decodes mode/op_code/S into execute and memory
// control, with bubble/squash/hold handling and a front-end stall for multi-cycle memory ops.
module control_unit_pipe #(
    parameter int CMD_W       = 4,
    parameter int MEM_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_in,
    input  logic [1:0]       mode,
    input  logic [3:0]       op_code,
    input  logic             hazard,
    input  logic             flush,
    input  logic             freeze,
    output logic             valid_out,
    output logic             wb_en,
    output logic             mem_r_en,
    output logic             mem_w_en,
    output logic             b,
    output logic             s_out,
    output logic [CMD_W-1:0] exe_cmd,
    output logic             illegal,
    output logic             mem_stall
);

    localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic {IDLE, WAIT} seq_state_t;

    seq_state_t state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic dec_wb, dec_mr, dec_mw, dec_b, dec_s, dec_illegal;
    logic [3:0] dec_cmd;

    logic valid_reg, wb_reg, mr_reg, mw_reg, b_reg, s_reg, illegal_reg;
    logic valid_next, wb_next, mr_next, mw_next, b_next, s_next, illegal_next;
    logic [CMD_W-1:0] cmd_reg, cmd_next;
    logic load_dec;

    always_comb begin
        dec_wb      = 1'b0;
        dec_mr      = 1'b0;
        dec_mw      = 1'b0;
        dec_b       = 1'b0;
        dec_s       = 1'b0;
        dec_cmd     = 4'b0000;
        dec_illegal = 1'b0;
        case (mode)
            2'b00: begin
                dec_wb = 1'b1;
                dec_s  = s_in;
                case (op_code)
                    4'b1101: dec_cmd = 4'b0001;
                    4'b1111: dec_cmd = 4'b1001;
                    4'b0100: dec_cmd = 4'b0010;
                    4'b0101: dec_cmd = 4'b0011;
                    4'b0110: dec_cmd = 4'b0101;
                    4'b0010: dec_cmd = 4'b0100;
                    4'b0000: dec_cmd = 4'b0110;
                    4'b1100: dec_cmd = 4'b0111;
                    4'b0001: dec_cmd = 4'b1000;
                    4'b1010: begin
                        dec_cmd = 4'b0100;
                        dec_wb  = 1'b0;
                        dec_s   = 1'b1;
                    end
                    4'b1000: begin
                        dec_cmd = 4'b0110;
                        dec_wb  = 1'b0;
                        dec_s   = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            2'b01: begin
                dec_cmd = 4'b0010;
                dec_mr  = s_in;
                dec_mw  = ~s_in;
                dec_wb  = s_in;
            end
            2'b10: dec_b = 1'b1;
            default: dec_illegal = 1'b1;
        endcase
    end

    assign mem_stall = (cnt_reg != '0);

    // Stall outranks flush: the memory op in EXE/MEM must not be squashed mid-access.
    always_comb begin
        valid_next   = valid_reg;
        wb_next      = wb_reg;
        mr_next      = mr_reg;
        mw_next      = mw_reg;
        b_next       = b_reg;
        s_next       = s_reg;
        cmd_next     = cmd_reg;
        illegal_next = illegal_reg;
        load_dec     = 1'b0;
        if (!mem_stall) begin
            if (flush || (!freeze && hazard) || (!freeze && dec_illegal)) begin
                valid_next   = 1'b0;
                wb_next      = 1'b0;
                mr_next      = 1'b0;
                mw_next      = 1'b0;
                b_next       = 1'b0;
                s_next       = 1'b0;
                cmd_next     = '0;
                illegal_next = !flush && !hazard && dec_illegal;
            end else if (!freeze) begin
                load_dec     = 1'b1;
                valid_next   = 1'b1;
                wb_next      = dec_wb;
                mr_next      = dec_mr;
                mw_next      = dec_mw;
                b_next       = dec_b;
                s_next       = dec_s;
                cmd_next     = CMD_W'(dec_cmd);
                illegal_next = 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (load_dec && mode == 2'b01 && MEM_LATENCY > 1) begin
                    cnt_next   = CNT_LOAD;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!freeze) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            valid_reg   <= 1'b0;
            wb_reg      <= 1'b0;
            mr_reg      <= 1'b0;
            mw_reg      <= 1'b0;
            b_reg       <= 1'b0;
            s_reg       <= 1'b0;
            cmd_reg     <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            valid_reg   <= valid_next;
            wb_reg      <= wb_next;
            mr_reg      <= mr_next;
            mw_reg      <= mw_next;
            b_reg       <= b_next;
            s_reg       <= s_next;
            cmd_reg     <= cmd_next;
            illegal_reg <= illegal_next;
        end
    end

    assign valid_out = valid_reg;
    assign wb_en     = wb_reg;
    assign mem_r_en  = mr_reg;
    assign mem_w_en  = mw_reg;
    assign b         = b_reg;
    assign s_out     = s_reg;
    assign exe_cmd   = cmd_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Bench for control_unit_pipe (MEM_LATENCY=3): directed scenarios, then random stimulus
// compared each cycle against a cycle-level behavioural model.
module tb_control_unit_pipe;

    localparam int ML = 3;

    logic clk = 1'b0;
    logic rst, s_in, hazard, flush, freeze;
    logic [1:0] mode;
    logic [3:0] op_code;
    logic valid_out, wb_en, mem_r_en, mem_w_en, b, s_out, illegal, mem_stall;
    logic [3:0] exe_cmd;

    int checks = 0;
    int failures = 0;

    // Model state: {valid, wb, mem_r, mem_w, b, s, cmd[3:0], illegal} and stall cycles left.
    logic [10:0] m_vec = '0;
    int stall_left = 0;

    control_unit_pipe #(.CMD_W(4), .MEM_LATENCY(ML)) dut (
        .clk(clk), .rst(rst), .s_in(s_in), .mode(mode), .op_code(op_code),
        .hazard(hazard), .flush(flush), .freeze(freeze),
        .valid_out(valid_out), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .b(b), .s_out(s_out), .exe_cmd(exe_cmd), .illegal(illegal), .mem_stall(mem_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] decode(input logic [1:0] md, input logic [3:0] op, input logic s);
        logic [3:0] cmd;
        logic wb, sf, ok;
        wb = 1'b1; sf = s; ok = 1'b1; cmd = 4'b0000;
        if (md == 2'b00) begin
            case (op)
                4'b1101: cmd = 4'b0001;  // MOV
                4'b1111: cmd = 4'b1001;  // MVN
                4'b0100: cmd = 4'b0010;  // ADD
                4'b0101: cmd = 4'b0011;  // ADC
                4'b0110: cmd = 4'b0101;  // SBC
                4'b0010: cmd = 4'b0100;  // SUB
                4'b0000: cmd = 4'b0110;  // AND
                4'b1100: cmd = 4'b0111;  // ORR
                4'b0001: cmd = 4'b1000;  // EOR
                4'b1010: begin cmd = 4'b0100; wb = 1'b0; sf = 1'b1; end  // CMP
                4'b1000: begin cmd = 4'b0110; wb = 1'b0; sf = 1'b1; end  // TST
                default: ok = 1'b0;
            endcase
            return ok ? {1'b1, wb, 1'b0, 1'b0, 1'b0, sf, cmd, 1'b0} : 11'b000000_0000_1;
        end else if (md == 2'b01) begin
            return s ? {6'b111000, 4'b0010, 1'b0} : {6'b100100, 4'b0010, 1'b0};
        end else if (md == 2'b10) begin
            return {6'b100010, 4'b0000, 1'b0};
        end
        return 11'b000000_0000_1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [1:0] md, input logic [3:0] op,
                        input logic s, input logic hz, input logic fl, input logic fr);
        rst = r; mode = md; op_code = op; s_in = s; hazard = hz; flush = fl; freeze = fr;
        if (r) begin
            m_vec = '0;
            stall_left = 0;
        end else if (stall_left > 0) begin
            if (!fr) stall_left--;
        end else if (fl || (!fr && hz)) begin
            m_vec = '0;
        end else if (!fr) begin
            m_vec = decode(md, op, s);
            if (md == 2'b01) stall_left = ML - 1;
        end
        @(posedge clk);
        #1;
        chk({tag, "/regs"}, 16'({valid_out, wb_en, mem_r_en, mem_w_en, b, s_out, exe_cmd, illegal}),
            16'(m_vec));
        chk({tag, "/stall"}, 16'(mem_stall), 16'(stall_left > 0));
        $display("step %-12s mode=%b op=%b s=%b hz=%b fl=%b fr=%b rst=%b -> valid=%b cmd=%b ill=%b stall=%b",
                 tag, md, op, s, hz, fl, fr, r, valid_out, exe_cmd, illegal, mem_stall);
    endtask

    initial begin
        rst = 1'b1; mode = '0; op_code = '0; s_in = 1'b0; hazard = 1'b0; flush = 1'b0; freeze = 1'b0;
        @(posedge clk); #1;
        step("reset", 1, 2'b00, 4'b0100, 1, 0, 0, 0);
        chk("reset_all_zero", 16'({valid_out, wb_en, mem_r_en, mem_w_en, b, s_out, exe_cmd, illegal, mem_stall}), 16'h0);

        step("add", 0, 2'b00, 4'b0100, 1, 0, 0, 0);
        chk("add_fields", 16'({exe_cmd, wb_en, s_out, valid_out}), 16'({4'b0010, 3'b111}));
        step("cmp", 0, 2'b00, 4'b1010, 0, 0, 0, 0);
        chk("cmp_fields", 16'({exe_cmd, wb_en, s_out}), 16'({4'b0100, 2'b01}));
        step("illegal", 0, 2'b00, 4'b0011, 0, 0, 0, 0);
        chk("illegal_fields", 16'({illegal, valid_out, wb_en, mem_r_en, mem_w_en, b}), 16'b100000);
        step("ill_hold", 0, 2'b00, 4'b0100, 0, 0, 0, 1);
        chk("illegal_held", 16'(illegal), 16'(1));

        // Load, then flush while stalled: flush must be ignored.
        step("load", 0, 2'b01, 4'b0000, 1, 0, 0, 0);
        step("load_flush", 0, 2'b00, 4'b0100, 0, 0, 1, 0);
        chk("load_survives_flush", 16'({mem_r_en, wb_en, mem_stall}), 16'b111);
        step("load_c3", 0, 2'b00, 4'b0100, 0, 0, 0, 0);
        chk("load_c3", 16'({mem_r_en, mem_stall}), 16'b10);
        step("after_load", 0, 2'b00, 4'b0100, 0, 0, 0, 0);

        // Store with two frozen cycles mid-WAIT: held 5 cycles, stalled 4.
        step("store", 0, 2'b01, 4'b0000, 0, 0, 0, 0);
        step("st_w1", 0, 2'b00, 4'b1101, 0, 0, 0, 0);
        step("st_frz1", 0, 2'b00, 4'b1101, 0, 0, 0, 1);
        step("st_frz2", 0, 2'b00, 4'b1101, 0, 0, 0, 1);
        step("st_w2", 0, 2'b00, 4'b1101, 0, 0, 0, 0);
        chk("store_5th", 16'({mem_w_en, mem_stall}), 16'b10);
        step("after_st", 0, 2'b00, 4'b1101, 0, 0, 0, 0);
        chk("mov_after_store", 16'({exe_cmd, mem_w_en}), 16'({4'b0001, 1'b0}));

        step("branch", 0, 2'b10, 4'b0000, 0, 0, 0, 0);
        chk("branch_b", 16'({b, exe_cmd}), 16'({1'b1, 4'b0000}));
        step("fl_hz", 0, 2'b00, 4'b0100, 0, 1, 1, 0);
        chk("single_bubble", 16'({valid_out, b}), 16'b00);
        step("frz_hz", 0, 2'b00, 4'b0100, 0, 1, 0, 1);
        step("add2", 0, 2'b00, 4'b0100, 0, 0, 0, 0);

        step("load2", 0, 2'b01, 4'b0000, 1, 0, 0, 0);
        step("rst_wait", 1, 2'b00, 4'b0100, 0, 0, 0, 0);
        chk("rst_abort", 16'({valid_out, mem_r_en, wb_en, mem_stall}), 16'b0000);
        step("post_rst", 0, 2'b00, 4'b1000, 1, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 99) < 2), 2'($urandom), 4'($urandom), 1'($urandom),
                 ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 20));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit_pipe.md
# control_unit_pipe

Parametrised, registered successor to the combinational ID-stage control decoder. It decodes mode/op_code/S into execute and memory control and captures the result in the ID/EX control register. The register supports bubble insertion (hazard), squash (branch flush) and hold (freeze). A built-in sequencer stalls the front end for multi-cycle memory accesses. It sits between instruction decode and the EXE stage of the pipelined core.

## Interface
- CMD_W, 4: width of exe_cmd; ≥4; 4-bit command codes are zero-extended.
- MEM_LATENCY, 1: cycles a load/store occupies EXE/MEM; ≥1; 1 means no stall.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_in  in  1  instruction S bit (set-flags; for mode 01, 1 = load).
- mode  in  2  instruction class: 00 data-proc, 01 memory, 10 branch, 11 reserved.
- op_code  in  4  data-processing opcode.
- hazard  in  1  load a bubble instead of the decoded instruction.
- flush  in  1  branch taken; squash the register contents.
- freeze  in  1  external hold; the register and counter keep their values.
- valid_out  out  1  register holds a real instruction.
- wb_en, mem_r_en, mem_w_en, b, s_out  out  1 each  registered control.
- exe_cmd  out  CMD_W  registered ALU command.
- illegal  out  1  registered; the instruction captured was undecodable, so a bubble was loaded.
- mem_stall  out  1  the front end must hold; combinational from the counter.

## Operation
- Decode, mode 00 (op_code -> exe_cmd, wb_en=1, s_out=s_in):
  - MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SBC 0110->0101.
  - SUB 0010->0100, AND 0000->0110, ORR 1100->0111, EOR 0001->1000.
  - CMP 1010->0100 and TST 1000->0110 use wb_en=0 and s_out=1.
- Mode 00, any other op_code: illegal.
- Mode 01: exe_cmd=0010, s_out=0.
  - s_in=1 is a load: mem_r_en=1, wb_en=1.
  - s_in=0 is a store: mem_w_en=1, wb_en=0.
- Mode 10: b=1, exe_cmd=0, all other enables 0.
- Mode 11: illegal.
- Bubble: all enables 0, exe_cmd=0, s_out=0, valid_out=0.
- Illegal: loads a bubble with illegal=1. illegal is 0 for every other load, and it holds while the register holds.
- Register update priority, highest first:
  - rst: bubble, illegal=0, counter=0.
  - mem_stall=1: hold; flush and hazard are ignored.
  - flush: bubble.
  - freeze: hold.
  - hazard: bubble.
  - otherwise: load the decode, valid_out=1 (0 if illegal).
- Memory sequencer states:
  - IDLE (cnt=0): loading a mem op with MEM_LATENCY>1 sets cnt=MEM_LATENCY-1 and enters WAIT.
  - WAIT (cnt>0): mem_stall=1. cnt decrements each cycle in which freeze=0. At cnt=0 the block returns to IDLE.
- Counter width: $clog2(MEM_LATENCY)+1; it never wraps.
- The same mem op stays in the register for exactly MEM_LATENCY unfrozen cycles. The next instruction loads on the first cycle with mem_stall=0.

## Timing
- Decode-to-output latency is 1 cycle. Inputs are sampled on the edge at which the register loads.
- mem_stall rises in the cycle after a mem op is loaded. It stays high for MEM_LATENCY-1 unfrozen cycles.
- After reset, every output is 0; valid_out=0 and mem_stall=0.
- rst mid-WAIT aborts the access on that edge.
- flush and hazard together give one bubble.
- freeze and hazard together: the register holds; no bubble is loaded.
- Back-to-back mem ops: the second loads the cycle after mem_stall falls, then re-enters WAIT.
- With MEM_LATENCY=1, mem_stall is constantly 0 and the block behaves as a plain decode register.

## Test plan
- Reset, then mode=00 op=0100 s_in=1 -> next cycle: exe_cmd=0010, wb_en=1, s_out=1, valid_out=1.
- Mode=00 op=1010 s_in=0 -> exe_cmd=0100, wb_en=0, s_out=1. Then op=0011 -> illegal=1, valid_out=0, all enables 0.
- MEM_LATENCY=3, load (mode 01, s_in=1) -> mem_r_en=1, wb_en=1 for 3 cycles; mem_stall=1 for cycles 2-3. Flush asserted during cycle 2 is ignored.
- MEM_LATENCY=3, store, with freeze=1 for 2 cycles mid-WAIT -> the store is held for 5 cycles and mem_stall for 4.
- Branch (mode 10) loaded, then flush=1 with hazard=1 -> b=1 for one cycle, then a single bubble. rst asserted mid-WAIT -> all outputs 0 on the next edge.
